collision_engine: RTL
=====================

Name: collision_engine

Overview:
- Per-frame collision checker between the dino and up to NUM_OBJ obstacle/enemy boxes of arbitrary size.
- Snapshots all boxes on frame_tick, then scans them one per cycle through a single overlap comparator.
- Resolves the scan into a hit event, lives counter, invulnerability grace period and sticky is_alive.
- Sits between the object generators and the game-state/VGA logic.

Parameters:
NUM_OBJ, 4, number of object slots scanned per frame (1..16)
COORD_W, 10, width of h/v coordinates
SIZE_W, 8, width of object width/height fields
DINO_W, 40, dino box width in pixels
DINO_H, 40, dino box height in pixels
MARGIN, 0, forgiveness pixels; each box edge is shrunk by MARGIN on the dino side
LIVES, 3, lives at reset (1..15)
GRACE_FRAMES, 60, frames of invulnerability after a non-fatal hit

Ports:
clk  in  1  system clock
clr  in  1  asynchronous active-high reset
frame_tick  in  1  one-cycle pulse, start of frame; starts a scan
dino_h  in  COORD_W  dino left edge
dino_v  in  COORD_W  dino top edge
obj_h  in  NUM_OBJ*COORD_W  object left edges, slot i at bits [i*COORD_W +: COORD_W]
obj_v  in  NUM_OBJ*COORD_W  object top edges
obj_w  in  NUM_OBJ*SIZE_W  object widths
obj_ht  in  NUM_OBJ*SIZE_W  object heights
obj_valid  in  NUM_OBJ  slot enable; invalid slots never collide
is_alive  out  1  high until lives reach 0
lives_left  out  4  remaining lives
hit  out  1  one-cycle pulse on a counted hit
hit_idx  out  4  lowest colliding slot index of the last counted hit
invuln  out  1  grace period active
busy  out  1  scan in progress
overrun  out  1  sticky; frame_tick arrived while busy

Behaviour:
- Reset values: is_alive=1, lives_left=LIVES, hit=0, hit_idx=0, invuln=0, busy=0, overrun=0, state=IDLE, grace count=0.
- FSM states: IDLE, SCAN, RESOLVE, DEAD.
- IDLE, with frame_tick and is_alive: snapshot all inputs including obj_valid; idx=0; any_hit=0; first_idx=0; busy=1; go to SCAN.
- SCAN: one slot per cycle, evaluating snapshot slot idx. On overlap && valid: set any_hit; set first_idx=idx if this is the first hit.
- SCAN exit: after idx=NUM_OBJ-1, go to RESOLVE.
- Latency: tick sampled at edge T. Slots are evaluated at edges T+1..T+NUM_OBJ. Outputs update at edge T+NUM_OBJ+1, where busy drops.
- Overlap test: strict AABB in COORD_W+2-bit unsigned arithmetic, so no wrap. Overlap iff all of:
  - dino_h+MARGIN < oh+ow
  - oh+MARGIN < dino_h+DINO_W
  - dino_v+MARGIN < ov+oht
  - ov+MARGIN < dino_v+DINO_H
- Touching edges do not overlap. Zero width or height never collides.
- RESOLVE (single cycle):
  - Grace update: if invuln, decrement grace count, and clear invuln when it reaches 0. This runs every resolved frame.
  - If any_hit and not invuln (value at the start of the cycle): hit=1 for one cycle, hit_idx=first_idx, lives_left-=1.
  - If the new lives value is 0: is_alive=0 and go to DEAD.
  - Otherwise: invuln=1, grace count=GRACE_FRAMES, go to IDLE.
  - Hits while invuln are ignored entirely: no pulse, no hit_idx update.
- DEAD: terminal. frame_tick is ignored, outputs are frozen, and only clr exits.
- frame_tick while busy (SCAN/RESOLVE): ignored and sets overrun=1. overrun is cleared only by clr.
- GRACE_FRAMES=0: invuln is never set, so every hit frame costs a life.
- clr mid-scan: immediate return to all reset values. The partial scan is discarded.

Decomposition:
- Package dino_collision_pkg holds:
  - state encoding (IDLE/SCAN/RESOLVE/DEAD)
  - LIVES_W=4 and IDX_W=4 constants
  - function for the widened unsigned add
- Sub-module aabb_overlap: purely combinational, parametrised by COORD_W, SIZE_W, DINO_W, DINO_H, MARGIN. It is instantiated once and muxed by idx.

Test Plan:
- NUM_OBJ=4. Dino (50,200). Slot2 valid at (70,210) 20x20, others invalid. Pulse tick → at T+5: hit=1 for one cycle, hit_idx=2, lives_left=2, invuln=1, is_alive=1.
- Touching edge: slot0 at (90,200) 20x20 → no hit. Move to (89,200) → hit, hit_idx=0.
- Slots 1 and 3 both overlapping → hit_idx=1. Repeat tick on the next frames with the overlap kept → no hit pulse while invuln. With GRACE_FRAMES=3, invuln clears after the 3rd resolved frame and the next overlapping frame hits.
- LIVES=1, one overlapping frame → is_alive=0, lives_left=0, and further ticks leave busy=0 and all outputs frozen. Then clr → is_alive=1, lives_left=1.
- Tick at T and again at T+2 → overrun=1 sticky, and the scan still completes at T+5.
- Assert clr at T+2 mid-scan with an overlap present → busy=0, lives_left=LIVES, no hit pulse.

Source files
------------

// File: rtl/dino_collision_pkg.sv
// Shared types and helpers for the dino collision engine: FSM encoding,
// counter widths and the widened add used by the overlap comparator.
package dino_collision_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DEAD    = 2'd3
  } state_e;

  localparam int LIVES_W = 4;
  localparam int IDX_W   = 4;

  function automatic logic [31:0] wide_add(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Strict axis-aligned box overlap between the dino box and one object box.
// Sums are formed two bits wider than the coordinates so edges never wrap.
module aabb_overlap
  import dino_collision_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int SIZE_W  = 8,
  parameter int DINO_W  = 40,
  parameter int DINO_H  = 40,
  parameter int MARGIN  = 0
) (
  input  logic [COORD_W-1:0] dino_h,
  input  logic [COORD_W-1:0] dino_v,
  input  logic [COORD_W-1:0] obj_h,
  input  logic [COORD_W-1:0] obj_v,
  input  logic [SIZE_W-1:0]  obj_w,
  input  logic [SIZE_W-1:0]  obj_ht,
  output logic               overlap
);

  localparam int AW = COORD_W + 2;

  logic [AW-1:0] d_left_s, d_right_s, o_left_s, o_right_s;
  logic [AW-1:0] d_top_s, d_bot_s, o_top_s, o_bot_s;
  logic          nonzero_s;

  assign d_left_s  = AW'(wide_add(32'(dino_h), 32'(MARGIN)));
  assign o_right_s = AW'(wide_add(32'(obj_h), 32'(obj_w)));
  assign o_left_s  = AW'(wide_add(32'(obj_h), 32'(MARGIN)));
  assign d_right_s = AW'(wide_add(32'(dino_h), 32'(DINO_W)));
  assign d_top_s   = AW'(wide_add(32'(dino_v), 32'(MARGIN)));
  assign o_bot_s   = AW'(wide_add(32'(obj_v), 32'(obj_ht)));
  assign o_top_s   = AW'(wide_add(32'(obj_v), 32'(MARGIN)));
  assign d_bot_s   = AW'(wide_add(32'(dino_v), 32'(DINO_H)));

  // A degenerate box could still satisfy the edge tests when MARGIN is 0.
  assign nonzero_s = (obj_w != {SIZE_W{1'b0}}) && (obj_ht != {SIZE_W{1'b0}});

  assign overlap = nonzero_s
                && (d_left_s < o_right_s) && (o_left_s < d_right_s)
                && (d_top_s  < o_bot_s)   && (o_top_s  < d_bot_s);

endmodule

// File: rtl/collision_engine.sv
// Per-frame dino collision checker: snapshots all object boxes on frame_tick,
// scans them one per cycle and resolves hits into lives, grace and alive state.
module collision_engine
  import dino_collision_pkg::*;
#(
  parameter int NUM_OBJ      = 4,
  parameter int COORD_W      = 10,
  parameter int SIZE_W       = 8,
  parameter int DINO_W       = 40,
  parameter int DINO_H       = 40,
  parameter int MARGIN       = 0,
  parameter int LIVES        = 3,
  parameter int GRACE_FRAMES = 60
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       frame_tick,
  input  logic [COORD_W-1:0]         dino_h,
  input  logic [COORD_W-1:0]         dino_v,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_h,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_v,
  input  logic [NUM_OBJ*SIZE_W-1:0]  obj_w,
  input  logic [NUM_OBJ*SIZE_W-1:0]  obj_ht,
  input  logic [NUM_OBJ-1:0]         obj_valid,
  output logic                       is_alive,
  output logic [LIVES_W-1:0]         lives_left,
  output logic                       hit,
  output logic [IDX_W-1:0]           hit_idx,
  output logic                       invuln,
  output logic                       busy,
  output logic                       overrun
);

  localparam int GW = (GRACE_FRAMES < 2) ? 1 : $clog2(GRACE_FRAMES + 1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       any_hit_q, any_hit_d;
  logic [IDX_W-1:0]           first_idx_q, first_idx_d;
  logic [COORD_W-1:0]         snap_dh_q, snap_dh_d, snap_dv_q, snap_dv_d;
  logic [NUM_OBJ*COORD_W-1:0] snap_oh_q, snap_oh_d, snap_ov_q, snap_ov_d;
  logic [NUM_OBJ*SIZE_W-1:0]  snap_ow_q, snap_ow_d, snap_oht_q, snap_oht_d;
  logic [NUM_OBJ-1:0]         snap_valid_q, snap_valid_d;
  logic [GW-1:0]              grace_q, grace_d;
  logic [LIVES_W-1:0]         lives_q, lives_d;
  logic                       alive_q, alive_d;
  logic                       hit_q, hit_d;
  logic [IDX_W-1:0]           hit_idx_q, hit_idx_d;
  logic                       invuln_q, invuln_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;

  logic [COORD_W-1:0] sel_h_s, sel_v_s;
  logic [SIZE_W-1:0]  sel_w_s, sel_ht_s;
  logic               sel_valid_s;
  logic               overlap_s;
  logic               slot_hit_s;
  logic [GW-1:0]      grace_dec_s;

  // Select the snapshot slot currently addressed by the scan index.
  always_comb begin
    sel_h_s     = {COORD_W{1'b0}};
    sel_v_s     = {COORD_W{1'b0}};
    sel_w_s     = {SIZE_W{1'b0}};
    sel_ht_s    = {SIZE_W{1'b0}};
    sel_valid_s = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      sel_h_s     = (idx_q == IDX_W'(i)) ? snap_oh_q[i*COORD_W +: COORD_W] : sel_h_s;
      sel_v_s     = (idx_q == IDX_W'(i)) ? snap_ov_q[i*COORD_W +: COORD_W] : sel_v_s;
      sel_w_s     = (idx_q == IDX_W'(i)) ? snap_ow_q[i*SIZE_W +: SIZE_W]   : sel_w_s;
      sel_ht_s    = (idx_q == IDX_W'(i)) ? snap_oht_q[i*SIZE_W +: SIZE_W]  : sel_ht_s;
      sel_valid_s = (idx_q == IDX_W'(i)) ? snap_valid_q[i]                 : sel_valid_s;
    end
  end

  aabb_overlap #(
    .COORD_W (COORD_W),
    .SIZE_W  (SIZE_W),
    .DINO_W  (DINO_W),
    .DINO_H  (DINO_H),
    .MARGIN  (MARGIN)
  ) u_overlap (
    .dino_h  (snap_dh_q),
    .dino_v  (snap_dv_q),
    .obj_h   (sel_h_s),
    .obj_v   (sel_v_s),
    .obj_w   (sel_w_s),
    .obj_ht  (sel_ht_s),
    .overlap (overlap_s)
  );

  assign slot_hit_s  = overlap_s & sel_valid_s;
  assign grace_dec_s = grace_q - GW'(1);

  // Next-state and output computation for the scan/resolve FSM.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    any_hit_d    = any_hit_q;
    first_idx_d  = first_idx_q;
    snap_dh_d    = snap_dh_q;
    snap_dv_d    = snap_dv_q;
    snap_oh_d    = snap_oh_q;
    snap_ov_d    = snap_ov_q;
    snap_ow_d    = snap_ow_q;
    snap_oht_d   = snap_oht_q;
    snap_valid_d = snap_valid_q;
    grace_d      = grace_q;
    lives_d      = lives_q;
    alive_d      = alive_q;
    hit_d        = 1'b0;
    hit_idx_d    = hit_idx_q;
    invuln_d     = invuln_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q;

    if (frame_tick && (state_q == ST_SCAN || state_q == ST_RESOLVE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_tick && alive_q) begin
          snap_dh_d    = dino_h;
          snap_dv_d    = dino_v;
          snap_oh_d    = obj_h;
          snap_ov_d    = obj_v;
          snap_ow_d    = obj_w;
          snap_oht_d   = obj_ht;
          snap_valid_d = obj_valid;
          idx_d        = {IDX_W{1'b0}};
          any_hit_d    = 1'b0;
          first_idx_d  = {IDX_W{1'b0}};
          busy_d       = 1'b1;
          state_d      = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (slot_hit_s && !any_hit_q) begin
          first_idx_d = idx_q;
        end else begin
          first_idx_d = first_idx_q;
        end
        any_hit_d = any_hit_q | slot_hit_s;
        if (idx_q == IDX_W'(NUM_OBJ - 1)) begin
          state_d = ST_RESOLVE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_RESOLVE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (invuln_q) begin
          grace_d  = grace_dec_s;
          invuln_d = (grace_dec_s != {GW{1'b0}});
        end else begin
          grace_d = grace_q;
        end
        // Invulnerability is judged on its value at the start of this cycle.
        if (any_hit_q && !invuln_q) begin
          hit_d     = 1'b1;
          hit_idx_d = first_idx_q;
          lives_d   = lives_q - 4'd1;
          if (lives_q == 4'd1) begin
            alive_d = 1'b0;
            state_d = ST_DEAD;
          end else begin
            invuln_d = (GRACE_FRAMES != 0);
            grace_d  = GW'(GRACE_FRAMES);
          end
        end else begin
          hit_idx_d = hit_idx_q;
        end
      end
      ST_DEAD: begin
        state_d = ST_DEAD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with asynchronous clear back to the power-on values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      idx_q        <= {IDX_W{1'b0}};
      any_hit_q    <= 1'b0;
      first_idx_q  <= {IDX_W{1'b0}};
      snap_dh_q    <= {COORD_W{1'b0}};
      snap_dv_q    <= {COORD_W{1'b0}};
      snap_oh_q    <= {(NUM_OBJ*COORD_W){1'b0}};
      snap_ov_q    <= {(NUM_OBJ*COORD_W){1'b0}};
      snap_ow_q    <= {(NUM_OBJ*SIZE_W){1'b0}};
      snap_oht_q   <= {(NUM_OBJ*SIZE_W){1'b0}};
      snap_valid_q <= {NUM_OBJ{1'b0}};
      grace_q      <= {GW{1'b0}};
      lives_q      <= LIVES_W'(LIVES);
      alive_q      <= 1'b1;
      hit_q        <= 1'b0;
      hit_idx_q    <= {IDX_W{1'b0}};
      invuln_q     <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      any_hit_q    <= any_hit_d;
      first_idx_q  <= first_idx_d;
      snap_dh_q    <= snap_dh_d;
      snap_dv_q    <= snap_dv_d;
      snap_oh_q    <= snap_oh_d;
      snap_ov_q    <= snap_ov_d;
      snap_ow_q    <= snap_ow_d;
      snap_oht_q   <= snap_oht_d;
      snap_valid_q <= snap_valid_d;
      grace_q      <= grace_d;
      lives_q      <= lives_d;
      alive_q      <= alive_d;
      hit_q        <= hit_d;
      hit_idx_q    <= hit_idx_d;
      invuln_q     <= invuln_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign is_alive   = alive_q;
  assign lives_left = lives_q;
  assign hit        = hit_q;
  assign hit_idx    = hit_idx_q;
  assign invuln     = invuln_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
